// File: rtl/axi_lite_adc_ctrl.sv
// AXI4-Lite controller for an 8-bit pipelined parallel ADC: divider-generated adc_clk, single-shot capture.
// Optional continuous capture mode is compiled in with `define AXI_ADC_CONT_EN.
module axi_lite_adc_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int DIV_RESET  = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  adc_clk,
  input  logic [7:0]            adc_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int PW = $clog2(PIPE_DEPTH + 2);
  localparam logic [PW-1:0] LP_PULSE_LAST = PW'(PIPE_DEPTH);
  localparam logic [PW-1:0] LP_PULSE_END  = PW'(PIPE_DEPTH + 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_bvalid;
  logic          r_rvalid;
  logic [31:0]   r_rdata;
  logic [15:0]   r_clk_div;
  logic [15:0]   r_half;
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_pulse;
  logic          r_adc_clk;
  logic          r_start;
  logic [7:0]    r_data;

  logic          w_wr_fire;
  logic          w_rd_fire;
  logic          w_ctl_wr;
  logic          w_div_wr;
  logic          w_stop_req;
  logic          w_start_req;
  logic          w_busy;
  logic          w_cont_mode;
  logic          w_half_end;
  logic          w_low_end;
  logic [31:0]   w_wmask;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_unused = &{s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_wstrb};

  // Write channel: address and data are accepted together, only while no response is pending.
  assign w_wr_fire     = !areset && s_axi_awvalid && s_axi_wvalid && !r_bvalid;
  assign s_axi_awready = w_wr_fire;
  assign s_axi_wready  = w_wr_fire;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = 2'b00;

  assign w_rd_fire     = !areset && s_axi_arvalid && !r_rvalid;
  assign s_axi_arready = w_rd_fire;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;

  assign adc_clk = r_adc_clk;
  assign w_busy  = (r_state != ST_IDLE);

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign w_wmask[gi*8 +: 8] = {8{s_axi_wstrb[gi]}};
  end

  assign w_ctl_wr    = w_wr_fire && (s_axi_awaddr[3:2] == 2'd0) && s_axi_wstrb[0];
  assign w_div_wr    = w_wr_fire && (s_axi_awaddr[3:2] == 2'd1);
  assign w_stop_req  = w_ctl_wr && s_axi_wdata[1];
  assign w_start_req = w_ctl_wr && s_axi_wdata[0] && !s_axi_wdata[1] && (r_state == ST_IDLE);

`ifdef AXI_ADC_CONT_EN
  logic r_cont;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_cont <= 1'b0;
    end else if (w_ctl_wr) begin
      r_cont <= s_axi_wdata[3];
    end
  end

  assign w_cont_mode = r_cont;
`else
  assign w_cont_mode = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_bvalid <= 1'b0;
    end else if (w_wr_fire) begin
      r_bvalid <= 1'b1;
    end else if (s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_clk_div <= 16'(DIV_RESET);
    end else if (w_div_wr) begin
      r_clk_div <= (r_clk_div & ~w_wmask[15:0]) | (s_axi_wdata[15:0] & w_wmask[15:0]);
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (s_axi_araddr[3:2])
      2'd0: begin
        w_rd_data[0] = r_start;
        w_rd_data[2] = w_busy;
        w_rd_data[3] = w_cont_mode;
      end
      2'd1:    w_rd_data[15:0] = r_clk_div;
      2'd2:    w_rd_data[7:0]  = r_data;
      default: w_rd_data = '0;
    endcase
  end

  // rdata only loads on a fresh address, so it holds while the master stalls rready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_rd_fire) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign w_half_end = (r_cnt == r_half - 16'd1);
  assign w_low_end  = (r_state == ST_RUN) && w_half_end && !r_adc_clk;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_req) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_low_end && (r_pulse == LP_PULSE_END) && !w_cont_mode) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_stop_req) w_state_next = ST_IDLE;
  end

  // r_pulse counts completed falling edges; the capture happens on the final one
  // (and on every later one in continuous mode, where the counter saturates).
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_adc_clk <= 1'b0;
      r_cnt     <= '0;
      r_pulse   <= '0;
      r_half    <= 16'd1;
      r_start   <= 1'b0;
      r_data    <= '0;
    end else if (w_stop_req) begin
      r_adc_clk <= 1'b0;
      r_start   <= 1'b0;
      r_cnt     <= '0;
      r_pulse   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_req) begin
            r_start   <= 1'b1;
            r_adc_clk <= 1'b1;
            r_cnt     <= '0;
            r_pulse   <= '0;
            r_half    <= (r_clk_div == 16'd0) ? 16'd1 : r_clk_div;
          end
        end
        ST_RUN: begin
          if (!w_half_end) begin
            r_cnt <= r_cnt + 16'd1;
          end else begin
            r_cnt <= '0;
            if (r_adc_clk) begin
              r_adc_clk <= 1'b0;
              if (r_pulse >= LP_PULSE_LAST) r_data <= adc_data;
              if (r_pulse != LP_PULSE_END) r_pulse <= r_pulse + 1'b1;
            end else begin
              r_adc_clk <= (w_state_next == ST_RUN);
            end
          end
        end
        ST_DONE: begin
          r_start <= 1'b0;
        end
        default: begin
          r_adc_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_adc_ctrl.sv
// Randomized self-checking bench for axi_lite_adc_ctrl; a monitor models the ADC and records adc_clk behaviour.
module tb_axi_lite_adc_ctrl;

  localparam int PIPE_DEPTH = 3;
  localparam int NPULSE     = PIPE_DEPTH + 1;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [3:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [3:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic        adc_clk;
  logic [7:0]  adc_data = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int rd_cyc   = 0;

  int         rise_q[$];
  int         high_total = 0;
  logic       prev_clk = 1'b0;
  logic [7:0] last_fall_data = 8'h00;
  logic [7:0] exp_data = 8'h00;

  axi_lite_adc_ctrl #(
    .ADDR_WIDTH(4),
    .PIPE_DEPTH(PIPE_DEPTH),
    .DIV_RESET (4)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .adc_clk      (adc_clk),
    .adc_data     (adc_data)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // ADC model: new sample presented after each adc_clk rise; remember what was on the bus at each fall.
  always @(negedge aclk) begin
    prev_clk <= adc_clk;
    if (adc_clk) high_total <= high_total + 1;
    if (adc_clk && !prev_clk) begin
      rise_q.push_back(cyc);
      adc_data <= 8'($urandom);
    end
    if (!adc_clk && prev_clk) last_fall_data <= adc_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge aclk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    #1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 50) begin @(negedge aclk); #1; n++; end
    if (n >= 50) check("aw_w_ready_timeout", 0, 1);
    @(posedge aclk); #1;
    wr_cyc = cyc;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) check("bvalid_timeout", 0, 1);
    check("bresp", 32'(s_axi_bresp), 0);
    @(posedge aclk); #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, input int hold, output logic [31:0] data);
    int n;
    logic [31:0] first;
    bit stable;
    @(negedge aclk);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge aclk); #1; n++; end
    if (n >= 50) check("arready_timeout", 0, 1);
    @(posedge aclk); #1;
    rd_cyc = cyc;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) check("rvalid_timeout", 0, 1);
    first = s_axi_rdata;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge aclk);
      if (s_axi_rdata !== first || !s_axi_rvalid) stable = 1'b0;
    end
    if (hold > 0) check("rdata_stable", 32'(stable), 1);
    check("rresp", 32'(s_axi_rresp), 0);
    s_axi_rready = 1'b1;
    @(posedge aclk); #1;
    s_axi_rready = 1'b0;
    data = first;
  endtask

  // One single-shot conversion; expectations come from H = max(div,1) and the ADC model.
  task automatic conv(input int div, input bit poke);
    int h, n0, hi0, t0, n, span, nexp;
    bit per_ok;
    logic [31:0] d;
    h = (div == 0) ? 1 : div;
    nexp = NPULSE * 2 * h;
    axi_write(4'h4, 32'(div), 4'hF);
    n0  = rise_q.size();
    hi0 = high_total;
    axi_write(4'h0, 32'h1, 4'h1);
    t0 = wr_cyc;
    if (poke) begin
      repeat (3) @(posedge aclk);
      axi_write(4'h0, 32'h1, 4'h1);
    end
    d = 32'h4; n = 0;
    while (d[2] && n < 500) begin axi_read(4'h0, 0, d); n++; end
    if (n >= 500) check("busy_clear_timeout", 0, 1);
    span = rd_cyc - t0;
    check("busy_span", 32'((span >= nexp + 1) && (span <= nexp + 6)), 1);
    check("ctl_after_conv", d, 0);
    check("rise_count", 32'(rise_q.size() - n0), 32'(NPULSE));
    check("high_cycles", 32'(high_total - hi0), 32'(NPULSE * h));
    per_ok = 1'b1;
    for (int i = n0 + 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] != 2 * h) per_ok = 1'b0;
    check("adc_clk_period", 32'(per_ok), 1);
    exp_data = last_fall_data;
    axi_read(4'h8, 0, d);
    check("data", d, {24'h0, exp_data});
    repeat (6) @(negedge aclk);
    check("adc_clk_idle_low", 32'(adc_clk), 0);
    $display("conv div=%0d H=%0d poke=%0d span=%0d data=0x%02h", div, h, poke, span, d[7:0]);
  endtask

  initial begin
    logic [31:0] d;
    int rn;
    int divs[6];

    repeat (3) @(negedge aclk);
    check("rst_awready", 32'(s_axi_awready), 0);
    check("rst_bvalid", 32'(s_axi_bvalid), 0);
    check("rst_rvalid", 32'(s_axi_rvalid), 0);
    check("rst_adc_clk", 32'(adc_clk), 0);
    areset = 1'b0;
    axi_read(4'h0, 0, d); check("rst_ctl", d, 0);
    axi_read(4'h4, 0, d); check("rst_clk_div", d, 4);
    axi_read(4'h8, 0, d); check("rst_data", d, 0);
    axi_read(4'hC, 0, d); check("rst_reserved", d, 0);
    $display("reset reads done");

    divs[0] = 4; divs[1] = 7; divs[2] = 1; divs[3] = 0;
    divs[4] = int'($urandom_range(1, 5));
    divs[5] = int'($urandom_range(2, 9));
    foreach (divs[i]) conv(divs[i], 1'b0);
    conv(2, 1'b1);

    // STOP mid-conversion
    axi_write(4'h4, 32'h4, 4'hF);
    axi_write(4'h0, 32'h1, 4'h1);
    repeat (10) @(posedge aclk);
    axi_write(4'h0, 32'h2, 4'h1);
    check("stop_adc_clk", 32'(adc_clk), 0);
    axi_read(4'h0, 0, d); check("stop_ctl", d, 0);
    axi_read(4'h8, 0, d); check("stop_data_kept", d, {24'h0, exp_data});
    rn = rise_q.size();
    repeat (20) @(posedge aclk);
    check("stop_no_rise", 32'(rise_q.size()), 32'(rn));
    $display("stop mid-conversion data=0x%02h", d[7:0]);

    // START+STOP together, and read-modify-write of STOP while idle
    axi_write(4'h0, 32'h3, 4'h1);
    repeat (10) @(posedge aclk);
    check("start_stop_no_rise", 32'(rise_q.size()), 32'(rn));
    axi_read(4'h0, 0, d); check("start_stop_ctl", d, 0);
    axi_write(4'h0, d | 32'h2, 4'h1);
    axi_read(4'h0, 0, d); check("rmw_ctl", d, 0);
    axi_read(4'h8, 0, d); check("rmw_data", d, {24'h0, exp_data});
    $display("start+stop and idle stop rmw done");

    // Reset in the middle of a conversion
    axi_write(4'h4, 32'h3, 4'hF);
    axi_write(4'h0, 32'h1, 4'h1);
    repeat (7) @(posedge aclk);
    @(negedge aclk); areset = 1'b1;
    @(negedge aclk);
    check("midrst_adc_clk", 32'(adc_clk), 0);
    areset = 1'b0;
    axi_read(4'h0, 0, d); check("midrst_ctl", d, 0);
    axi_read(4'h4, 0, d); check("midrst_clk_div", d, 4);
    axi_read(4'h8, 0, d); check("midrst_data", d, 0);
    $display("reset mid-conversion done");

    // Byte strobes, RO/reserved writes, stalled reads
    axi_write(4'h4, 32'hFFFF_0102, 4'b0001);
    axi_read(4'h4, 3, d); check("wstrb_clk_div", d, 32'h2);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'h8, 3, d); check("data_ro", d, 0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'hC, 3, d); check("reserved_ro", d, 0);
    axi_write(4'h0, 32'hFFFF_FFF8, 4'hF);
    axi_read(4'h0, 3, d); check("ctl_unused_bits", d, 0);
    $display("strobe and read-stall checks done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
